// File: rtl/axi4s_pkt_arbiter.sv
// Two-input AXI4-Stream packet arbiter, fixed-length packets, round-robin grant.
// Define AXIS_ARB_FIXED_PRIO_EN to make source 0 always win a tie.
module axi4s_pkt_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 10
) (
    input  logic                    ACLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   S0_TDATA,
    input  logic                    S0_TVALID,
    output logic                    S0_TREADY,
    input  logic [DATA_WIDTH-1:0]   S1_TDATA,
    input  logic                    S1_TVALID,
    output logic                    S1_TREADY,
    output logic [DATA_WIDTH-1:0]   M_TDATA,
    output logic                    M_TVALID,
    input  logic                    M_TREADY,
    output logic                    M_TLAST,
    output logic [1:0]              M_TDEST,
    output logic [7:0]              M_TID,
    output logic [DATA_WIDTH/8-1:0] M_TKEEP,
    output logic [1:0]              GRANT,
    output logic [15:0]             PKT_CNT
);

    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t      state, state_nx;
    logic [1:0]  grant, grant_nx;
    logic        last_served, last_nx;
    logic [15:0] beat_cnt, beat_nx;
    logic [15:0] pkt_cnt, pkt_nx;
    logic        hs;
    logic        pick1;
    logic        at_last;

    assign hs      = M_TVALID & M_TREADY;
    assign at_last = (beat_cnt == LAST_BEAT);

`ifdef AXIS_ARB_FIXED_PRIO_EN
    assign pick1 = S1_TVALID & ~S0_TVALID;
`else
    assign pick1 = S1_TVALID & (~S0_TVALID | ~last_served);
`endif

    // State, grant and counters; reset abandons any partial packet.
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_served <= 1'b1;
            beat_cnt    <= 16'd0;
            pkt_cnt     <= 16'd0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            last_served <= last_nx;
            beat_cnt    <= beat_nx;
            pkt_cnt     <= pkt_nx;
        end
    end

    // Grant on a request in IDLE; release after the last-beat handshake.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last_served;
        beat_nx  = beat_cnt;
        pkt_nx   = pkt_cnt;
        unique case (state)
            IDLE: begin
                if (S0_TVALID | S1_TVALID) begin
                    state_nx = XFER;
                    grant_nx = pick1 ? 2'b10 : 2'b01;
                end
            end
            XFER: begin
                if (hs) begin
                    if (at_last) begin
                        beat_nx  = 16'd0;
                        pkt_nx   = pkt_cnt + 16'd1;
                        last_nx  = grant[1];
                        grant_nx = 2'b00;
                        state_nx = IDLE;
                    end else begin
                        beat_nx = beat_cnt + 16'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Combinational pass-through of the granted source.
    always_comb begin
        M_TVALID  = (grant[0] & S0_TVALID) | (grant[1] & S1_TVALID);
        M_TDATA   = '0;
        if (grant[1])
            M_TDATA = S1_TDATA;
        else if (grant[0])
            M_TDATA = S0_TDATA;
        S0_TREADY = grant[0] & M_TREADY;
        S1_TREADY = grant[1] & M_TREADY;
        M_TLAST   = at_last & M_TVALID;
        M_TDEST   = {1'b0, grant[1]};
        M_TID     = 8'h00;
        M_TKEEP   = {(DATA_WIDTH/8){M_TVALID}};
        GRANT     = grant;
        PKT_CNT   = pkt_cnt;
    end

endmodule

// File: tb/tb_axi4s_pkt_arbiter.sv
// Self-checking bench for axi4s_pkt_arbiter with a packet-level reference model.
// Honours AXIS_ARB_FIXED_PRIO_EN in the model when the build defines it.
module tb_axi4s_pkt_arbiter;

    localparam int DW = 32;
    localparam int PL = 10;
    localparam int KW = DW / 8;

    logic          ACLK = 1'b0;
    logic          RST  = 1'b1;
    logic [DW-1:0] s0_data = '0;
    logic [DW-1:0] s1_data = '0;
    logic          s0_valid = 1'b0;
    logic          s1_valid = 1'b0;
    logic          m_ready  = 1'b0;

    logic          S0_TREADY, S1_TREADY;
    logic [DW-1:0] M_TDATA;
    logic          M_TVALID, M_TLAST;
    logic [1:0]    M_TDEST;
    logic [7:0]    M_TID;
    logic [KW-1:0] M_TKEEP;
    logic [1:0]    GRANT;
    logic [15:0]   PKT_CNT;

    axi4s_pkt_arbiter #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .ACLK(ACLK), .RST(RST),
        .S0_TDATA(s0_data), .S0_TVALID(s0_valid), .S0_TREADY(S0_TREADY),
        .S1_TDATA(s1_data), .S1_TVALID(s1_valid), .S1_TREADY(S1_TREADY),
        .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(m_ready),
        .M_TLAST(M_TLAST), .M_TDEST(M_TDEST), .M_TID(M_TID),
        .M_TKEEP(M_TKEEP), .GRANT(GRANT), .PKT_CNT(PKT_CNT)
    );

    always #5 ACLK = ~ACLK;

    int passed = 0;
    int total  = 0;

    // Reference model: who owns the stream, beats delivered, history.
    int          owner;
    int          beats;
    int          last_srv;
    logic [15:0] pkts;

    logic [67:0] obs;
    assign obs = {M_TVALID, M_TDATA, M_TLAST, M_TDEST, M_TID, M_TKEEP,
                  S0_TREADY, S1_TREADY, GRANT, PKT_CNT};

    function automatic logic [67:0] expected();
        logic          v;
        logic [DW-1:0] d;
        logic [1:0]    g;
        if (owner < 0)
            return {52'b0, pkts};
        v = (owner == 0) ? s0_valid : s1_valid;
        d = (owner == 0) ? s0_data : s1_data;
        g = (owner == 0) ? 2'b01 : 2'b10;
        return {v, d, 1'(v && beats == PL - 1), 2'(owner), 8'h00,
                v ? {KW{1'b1}} : {KW{1'b0}},
                1'(owner == 0 && m_ready), 1'(owner == 1 && m_ready),
                g, pkts};
    endfunction

    task automatic model_reset();
        owner    = -1;
        beats    = 0;
        last_srv = 1;
        pkts     = 16'd0;
    endtask

    // Advance model and DUT by one rising edge; returns at the next falling edge.
    task automatic tick();
        int n_owner = owner;
        int n_beats = beats;
        int n_last  = last_srv;
        logic [15:0] n_pkts = pkts;
        logic v;
        if (owner < 0) begin
            if (s0_valid || s1_valid) begin
`ifdef AXIS_ARB_FIXED_PRIO_EN
                n_owner = s0_valid ? 0 : 1;
`else
                if (s0_valid && s1_valid)
                    n_owner = (last_srv == 0) ? 1 : 0;
                else
                    n_owner = s0_valid ? 0 : 1;
`endif
            end
        end else begin
            v = (owner == 0) ? s0_valid : s1_valid;
            if (v && m_ready) begin
                n_beats = beats + 1;
                if (n_beats == PL) begin
                    n_beats = 0;
                    n_pkts  = pkts + 16'd1;
                    n_last  = owner;
                    n_owner = -1;
                end
            end
        end
        @(posedge ACLK);
        owner    = n_owner;
        beats    = n_beats;
        last_srv = n_last;
        pkts     = n_pkts;
        @(negedge ACLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        m_ready  = 1'b1;
        s0_data  = $urandom;
        s1_data  = $urandom;
        @(negedge ACLK);
        #1;
        total++;
        if (obs !== expected())
            $display("FAIL reset_outputs got=%h want=%h", obs, expected());
        else
            passed++;
        total++;
        if (GRANT !== 2'b00 || PKT_CNT !== 16'd0)
            $display("FAIL reset_grant_cnt got=%b/%h want=00/0000", GRANT, PKT_CNT);
        else
            passed++;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        RST = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_both_continuous();
        int dests[$];
        int seen = 0;
        do_reset();
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        m_ready  = 1'b1;
        for (int i = 0; i < 44; i++) begin
            s0_data = $urandom;
            s1_data = $urandom;
            #1;
            total++;
            if (obs !== expected())
                $display("FAIL both_cyc%0d got=%h want=%h", i, obs, expected());
            else
                passed++;
            if (M_TVALID && m_ready) begin
                seen++;
                if (M_TLAST) begin
                    total++;
                    if (seen !== PL)
                        $display("FAIL both_pkt_len got=%0d want=%0d", seen, PL);
                    else
                        passed++;
                    dests.push_back(int'(M_TDEST));
                    seen = 0;
                end
            end
            tick();
        end
        total++;
        if (PKT_CNT !== 16'd4)
            $display("FAIL both_pkt_cnt got=%0d want=4", PKT_CNT);
        else
            passed++;
        total++;
        if (dests.size() != 4)
            $display("FAIL both_pkts got=%0d want=4", dests.size());
        else
            passed++;
        for (int k = 0; k < dests.size(); k++) begin
            total++;
`ifdef AXIS_ARB_FIXED_PRIO_EN
            if (dests[k] != 0)
                $display("FAIL fixed_dest%0d got=%0d want=0", k, dests[k]);
`else
            if (dests[k] != k % 2)
                $display("FAIL both_dest%0d got=%0d want=%0d", k, dests[k], k % 2);
`endif
            else
                passed++;
        end
    endtask

    task automatic test_s1_only();
        do_reset();
        s0_valid = 1'b0;
        s1_valid = 1'b1;
        m_ready  = 1'b1;
        for (int i = 0; i < 33; i++) begin
            s0_data = $urandom;
            s1_data = $urandom;
            #1;
            total++;
            if (obs !== expected())
                $display("FAIL s1only_cyc%0d got=%h want=%h", i, obs, expected());
            else if (S0_TREADY !== 1'b0 || (M_TVALID && M_TDEST !== 2'd1))
                $display("FAIL s1only_route got=%b/%0d want=0/1", S0_TREADY, M_TDEST);
            else
                passed++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] seq = 32'h100;
        int seen = 0;
        int lasts = 0;
        do_reset();
        s0_valid = 1'b0;
        s1_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            m_ready = (i % 2 == 0);
            s1_data = seq;
            #1;
            total++;
            if (obs !== expected())
                $display("FAIL bp_cyc%0d got=%h want=%h", i, obs, expected());
            else
                passed++;
            if (M_TVALID && m_ready) begin
                seen++;
                seq = seq + 1;
                if (M_TLAST) begin
                    lasts++;
                    total++;
                    if (seen !== PL)
                        $display("FAIL bp_pkt_len got=%0d want=%0d", seen, PL);
                    else
                        passed++;
                    seen = 0;
                end
            end
            tick();
        end
        total++;
        if (lasts < 2)
            $display("FAIL bp_pkts got=%0d want>=2", lasts);
        else
            passed++;
    endtask

    task automatic test_reset_mid();
        int hs0 = 0;
        int seen = 0;
        bit done = 0;
        do_reset();
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        m_ready  = 1'b1;
        for (int i = 0; i < 20 && hs0 < 4; i++) begin
            s0_data = $urandom;
            s1_data = $urandom;
            #1;
            if (M_TVALID && m_ready && M_TDEST == 2'd0)
                hs0++;
            tick();
        end
        total++;
        if (hs0 != 4)
            $display("FAIL rmid_reach got=%0d want=4", hs0);
        else
            passed++;
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        total++;
        if (obs !== expected() || M_TLAST !== 1'b0)
            $display("FAIL rmid_async got=%h want=%h", obs, expected());
        else
            passed++;
        @(negedge ACLK);
        RST = 1'b0;
        for (int i = 0; i < 14; i++) begin
            s0_data = $urandom;
            s1_data = $urandom;
            #1;
            total++;
            if (obs !== expected())
                $display("FAIL rmid_cyc%0d got=%h want=%h", i, obs, expected());
            else
                passed++;
            if (!done && M_TVALID && m_ready) begin
                seen++;
                if (M_TDEST !== 2'd0) begin
                    total++;
                    $display("FAIL rmid_dest got=%0d want=0", M_TDEST);
                end
                if (M_TLAST)
                    done = 1;
            end
            tick();
        end
        total++;
        if (!done || seen != PL)
            $display("FAIL rmid_len got=%0d want=%0d", seen, PL);
        else
            passed++;
    endtask

    task automatic test_random();
        logic [15:0] start;
        do_reset();
        start = PKT_CNT;
        for (int i = 0; i < 3000; i++) begin
            s0_valid = ($urandom_range(0, 3) != 0);
            s1_valid = ($urandom_range(0, 3) != 0);
            m_ready  = ($urandom_range(0, 3) != 0);
            s0_data  = $urandom;
            s1_data  = $urandom;
            #1;
            total++;
            if (obs !== expected())
                $display("FAIL rand_cyc%0d got=%h want=%h", i, obs, expected());
            else
                passed++;
            tick();
        end
        total++;
        if (PKT_CNT === start)
            $display("FAIL rand_progress got=%0d want>%0d", PKT_CNT, start);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_both_continuous();
        test_s1_only();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axi4s_pkt_arbiter.md
# axi4s_pkt_arbiter

Two-input AXI4-Stream packet arbiter that shares one AXI4-Stream master port between two sources. Arbitration happens only on packet boundaries, and each packet is exactly PKT_LEN beats long. The block generates TLAST, TDEST and TKEEP on the shared stream, so the sources only provide TDATA/TVALID. It sits between the fabric stream generators and the single stream sink, such as a DMA write channel.

## Interface
- DATA_WIDTH, 32, TDATA width in bits; must be a multiple of 8.
- PKT_LEN, 10, beats per packet; legal range 2..65535.
- ACLK  input  1  sole clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset; clears all state immediately.
- S0_TDATA  input  DATA_WIDTH  source 0 data.
- S0_TVALID  input  1  source 0 beat valid.
- S0_TREADY  output  1  source 0 beat accepted.
- S1_TDATA / S1_TVALID / S1_TREADY  same as source 0, for source 1.
- M_TDATA  output  DATA_WIDTH  granted source data; 0 when no grant.
- M_TVALID  output  1  shared stream valid.
- M_TREADY  input  1  sink ready.
- M_TLAST  output  1  high on the final (PKT_LEN-th) beat of a packet.
- M_TDEST  output  2  {1'b0, granted source index}.
- M_TID  output  8  constant 8'h00.
- M_TKEEP  output  DATA_WIDTH/8  all ones while M_TVALID is high, else 0.
- GRANT  output  2  one-hot registered grant; 2'b00 when idle.
- PKT_CNT  output  16  completed-packet counter; wraps 16'hFFFF -> 0.

## Operation
- FSM states:
  - IDLE, reset state.
  - XFER.
- IDLE:
  - If either Sx_TVALID is high, the block picks a winner per policy, registers GRANT, and moves to XFER at the next edge.
  - With no requests, it stays in IDLE.
- XFER:
  - Combinational pass-through of the granted source. M_TVALID = Sx_TVALID; Sx_TREADY = M_TREADY; M_TDATA = Sx_TDATA.
  - The non-granted source sees TREADY = 0.
- Beat counter (16 bit): increments on each M_TVALID & M_TREADY handshake.
- M_TLAST = (beat_cnt == PKT_LEN-1) & M_TVALID.
- On the handshake of the last beat:
  - beat_cnt clears to 0 and PKT_CNT increments.
  - last_served is set to the granted index and GRANT clears.
  - The FSM returns to IDLE.
- Round-robin policy:
  - When both sources request in IDLE, the source != last_served wins.
  - last_served resets to 1, so source 0 wins the first tie.
  - A single requester always wins, whatever last_served holds.
- If the granted source drops TVALID mid-packet, the grant is held and the block waits. There is no timeout and no preemption.
- Outputs after reset:
  - M_TVALID = 0, M_TLAST = 0, M_TDEST = 0, M_TKEEP = 0, M_TDATA = 0.
  - S0_TREADY = S1_TREADY = 0.
  - GRANT = 2'b00, PKT_CNT = 0.
- Reset mid-packet: the partial packet is abandoned with no TLAST. The FSM goes to IDLE with beat_cnt = 0 and last_served = 1.

## Timing
- Grant latency: a request in IDLE at edge N gives GRANT valid and the first beat presentable from edge N+1.
- The cycle following the last-beat handshake is always IDLE, so there is exactly 1 bubble between packets. Peak throughput is PKT_LEN/(PKT_LEN+1).
- Data path: zero-cycle combinational from Sx to M. M_TREADY reaches Sx_TREADY combinationally.
- M_TLAST, M_TDEST and M_TKEEP are stable while M_TVALID is high and M_TREADY is low.
- A request arriving in the same cycle as the last-beat handshake is considered in the following IDLE cycle.

## Configuration
- AXIS_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Source 0 always wins when both request; last_served is not used.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Both sources hold TVALID continuously with M_TREADY=1 and PKT_LEN=10:
  - Packets alternate with M_TDEST 0,1,0,1.
  - Each packet is 10 beats with M_TLAST on beat 10, and there is 1 idle cycle between packets.
  - PKT_CNT=4 after 44 cycles.
- Only S1 requests: every packet has M_TDEST=1 and S0_TREADY stays 0.
- M_TREADY toggles 1,0,1,0 during XFER:
  - The beat count advances only on handshakes.
  - M_TLAST is held across stalls, and M_TDATA matches the S1 sequence.
- RST asserted after beat 4 of a source-0 packet:
  - All outputs go to their reset values asynchronously.
  - After release, with both sources requesting, source 0 is granted and the new packet is a full 10 beats.
- PKT_CNT preloaded to 16'hFFFE by running 65534 packets: it wraps to 16'h0000 after 2 more packets.
- With AXIS_ARB_FIXED_PRIO_EN defined and both sources requesting continuously, only source 0 is ever granted.
